// File: rtl/tt_um_rr_priority_encoder.sv
// Request arbiter with selectable fixed-priority or round-robin search and a
// single registered valid/ready output slot that never retracts a grant.
module tt_um_rr_priority_encoder #(
  parameter int N = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [N-1:0]             req,
  input  logic                     mode,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [$clog2(N)-1:0]     out_idx,
  output logic [N-1:0]             gnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] PTR_TOP = IW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0] ptr;
  logic [IW-1:0] fix_idx;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] rr_cand;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] ptr_next;
  logic          any_req;
  logic          slot_free;

  assign any_req   = |req;
  assign slot_free = !out_valid || out_ready;

  // Highest set bit: later (higher) iterations overwrite earlier hits.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_idx = IW'(i);
    end
  end

  // Walk from the farthest candidate (ptr+1) back to ptr so the last hit,
  // i.e. the one closest to ptr in descending order, wins. The candidate
  // index is formed without a power-of-two wrap so it always stays below N.
  always_comb begin
    rr_idx  = '0;
    rr_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (int'(ptr) >= k) rr_cand = IW'(int'(ptr) - k);
      else                rr_cand = IW'(int'(ptr) + N - k);
      if (req[rr_cand]) rr_idx = rr_cand;
    end
  end

  assign win_idx  = mode ? rr_idx : fix_idx;
  assign ptr_next = (win_idx == '0) ? PTR_TOP : win_idx - IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      gnt       <= '0;
      ptr       <= PTR_TOP;
    end else if (ena && slot_free) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_idx   <= win_idx;
        gnt       <= ONE_HOT << win_idx;
        if (mode) ptr <= ptr_next;
      end else begin
        out_valid <= 1'b0;
        gnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_rr_priority_encoder.sv
// Directed vector bench for the round-robin/fixed priority arbiter.
module tb_tt_um_rr_priority_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, mode, out_ready;
  logic [15:0] req;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [15:0] gnt;

  logic        ena5, mode5, rdy5;
  logic [4:0]  req5;
  logic        valid5;
  logic [2:0]  idx5;
  logic [4:0]  gnt5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tt_um_rr_priority_encoder #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .mode(mode),
    .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx), .gnt(gnt)
  );

  tt_um_rr_priority_encoder #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .ena(ena5), .req(req5), .mode(mode5),
    .out_ready(rdy5), .out_valid(valid5), .out_idx(idx5), .gnt(gnt5)
  );

  typedef struct {
    logic        ena;
    logic        mode;
    logic [15:0] req;
    logic        rdy;
    logic        exp_v;
    logic [3:0]  exp_idx;
    logic [15:0] exp_gnt;
    logic [3:0]  exp_ptr;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic v, input logic [3:0] idx,
                           input logic [15:0] g, input logic [3:0] p);
    check({name, ".valid"}, 32'(out_valid), 32'(v));
    check({name, ".idx"},   32'(out_idx),   32'(idx));
    check({name, ".gnt"},   32'(gnt),       32'(g));
    check({name, ".ptr"},   32'(dut.ptr),   32'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ena mode req       rdy v  idx gnt       ptr
    vecs[0]  = '{1, 0, 16'h0091, 1, 1, 7,  16'h0080, 15};
    vecs[1]  = '{1, 0, 16'h0000, 1, 0, 7,  16'h0000, 15};
    vecs[2]  = '{1, 1, 16'h8001, 1, 1, 15, 16'h8000, 14};
    vecs[3]  = '{1, 1, 16'h8001, 1, 1, 0,  16'h0001, 15};
    vecs[4]  = '{1, 1, 16'h8001, 1, 1, 15, 16'h8000, 14};
    vecs[5]  = '{1, 1, 16'h8001, 1, 1, 0,  16'h0001, 15};
    vecs[6]  = '{1, 0, 16'h0090, 1, 1, 7,  16'h0080, 15};
    vecs[7]  = '{1, 0, 16'h0002, 0, 1, 7,  16'h0080, 15};
    vecs[8]  = '{1, 1, 16'h0004, 0, 1, 7,  16'h0080, 15};
    vecs[9]  = '{1, 0, 16'h0002, 1, 1, 1,  16'h0002, 15};
    vecs[10] = '{0, 1, 16'hffff, 1, 1, 1,  16'h0002, 15};
    vecs[11] = '{0, 1, 16'h0000, 1, 1, 1,  16'h0002, 15};
    vecs[12] = '{1, 1, 16'h0006, 1, 1, 2,  16'h0004, 1};
    vecs[13] = '{1, 1, 16'h0006, 1, 1, 1,  16'h0002, 0};
    vecs[14] = '{1, 1, 16'h0006, 1, 1, 2,  16'h0004, 1};
    vecs[15] = '{1, 1, 16'h0001, 1, 1, 0,  16'h0001, 15};
    vecs[16] = '{1, 1, 16'h0000, 1, 0, 0,  16'h0000, 15};
    vecs[17] = '{1, 1, 16'h0000, 0, 0, 0,  16'h0000, 15};
    vecs[18] = '{1, 1, 16'h0100, 0, 1, 8,  16'h0100, 7};
    vecs[19] = '{1, 1, 16'h8000, 0, 1, 8,  16'h0100, 7};

    rst_n = 1'b0; ena = 1'b1; mode = 1'b0; out_ready = 1'b1; req = 16'h0091;
    ena5 = 1'b0; mode5 = 1'b0; rdy5 = 1'b0; req5 = '0;
    step(); step();
    check_all("reset", 1'b0, 4'd0, 16'h0000, 4'd15);
    rst_n = 1'b1;
    #1;
    check_all("post_release_no_load", 1'b0, 4'd0, 16'h0000, 4'd15);

    for (int i = 0; i < 20; i++) begin
      ena = vecs[i].ena; mode = vecs[i].mode; req = vecs[i].req; out_ready = vecs[i].rdy;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_idx,
                vecs[i].exp_gnt, vecs[i].exp_ptr);
    end

    // Backpressure: grant 7 held for 5 cycles while req changes, then accepted.
    ena = 1'b1; mode = 1'b0; out_ready = 1'b1; req = 16'h0080;
    step();
    check_all("bp_load", 1'b1, 4'd7, 16'h0080, 4'd7);
    out_ready = 1'b0; req = 16'h0002;
    for (int c = 0; c < 5; c++) begin
      mode = c[0];
      step();
      check_all($sformatf("bp_hold%0d", c), 1'b1, 4'd7, 16'h0080, 4'd7);
    end
    mode = 1'b0; out_ready = 1'b1;
    step();
    check_all("bp_accept", 1'b1, 4'd1, 16'h0002, 4'd7);

    // Enable freeze: nothing moves while ena is low.
    ena = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req = c[0] ? 16'h00f0 : 16'h0000;
      out_ready = c[0];
      mode = ~c[0];
      step();
      check_all($sformatf("ena_hold%0d", c), 1'b1, 4'd1, 16'h0002, 4'd7);
    end
    ena = 1'b1; mode = 1'b1; out_ready = 1'b1; req = 16'h0010;
    step();
    check_all("ena_resume", 1'b1, 4'd4, 16'h0010, 4'd3);

    // Asynchronous reset between edges, then search restarts from N-1.
    req = 16'h0018;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 4'd0, 16'h0000, 4'd15);
    #1;
    rst_n = 1'b1;
    step();
    check_all("rst_first_load", 1'b1, 4'd4, 16'h0010, 4'd3);

    // Non-power-of-two wrap on the N=5 instance.
    check("n5_reset_ptr", 32'(dut5.ptr), 32'd4);
    ena5 = 1'b1; mode5 = 1'b1; rdy5 = 1'b1; req5 = 5'b10001;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("n5_valid%0d", c), 32'(valid5), 32'd1);
      check($sformatf("n5_idx%0d", c), 32'(idx5), (c % 2 == 0) ? 32'd4 : 32'd0);
      check($sformatf("n5_gnt%0d", c), 32'(gnt5), (c % 2 == 0) ? 32'h10 : 32'h01);
      check($sformatf("n5_ptr%0d", c), 32'(dut5.ptr), (c % 2 == 0) ? 32'd3 : 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
